// File: rtl/bpc_arbiter.sv
// bpc_arbiter: round-robin front end sharing one bit_population_counter
// among REQ_N requesters. Issues at most one word per cycle to the counter,
// logs the owner of each issued word in a tag FIFO, and routes each returned
// popcount to its owner with a one-hot valid.
//
// Ports
//   clk_i, rst_n_i           clock (rising edge), async active-low reset
//   req_data_i/req_val_i     per-requester words (k at [k*WIDTH +: WIDTH])
//   req_ready_o              one-hot (or zero) combinational grant
//   bpc_data_o/bpc_data_val_o  registered word to the counter
//   bpc_data_i/bpc_data_val_i  popcount back from the counter
//   res_data_o/res_val_o     registered result, one-hot owner valid
//   err_o                    sticky orphan-result flag
//
// Optional feature: define BPC_ARB_ERR_EN to build the orphan-result detector;
// otherwise err_o is tied low.
module bpc_arbiter #(
  parameter int REQ_N     = 4,
  parameter int WIDTH     = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [REQ_N*WIDTH-1:0]     req_data_i,
  input  logic [REQ_N-1:0]           req_val_i,
  output logic [REQ_N-1:0]           req_ready_o,
  output logic [WIDTH-1:0]           bpc_data_o,
  output logic                       bpc_data_val_o,
  input  logic [$clog2(WIDTH):0]     bpc_data_i,
  input  logic                       bpc_data_val_i,
  output logic [$clog2(WIDTH):0]     res_data_o,
  output logic [REQ_N-1:0]           res_val_o,
  output logic                       err_o
);
  localparam int PW = $clog2(REQ_N);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [REQ_N-1:0][WIDTH-1:0] words;
  assign words = req_data_i;

  logic [PW-1:0]       rr_q, rr_d;
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         cnt_q, cnt_d;
  logic [PW-1:0]       tag_mem [TAG_DEPTH];
  logic [WIDTH-1:0]    bpc_data_q;
  logic                bpc_val_q;
  logic [CW-1:0]       res_data_q;
  logic [REQ_N-1:0]    res_val_q;

  // Rotating-priority search starting at rr_q, wrapping at REQ_N.
  logic          found;
  logic [PW-1:0] gnt, sidx;
  int            scan;
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sidx  = '0;
    scan  = 0;
    for (int i = 0; i < REQ_N; i++) begin
      scan = int'(rr_q) + i;
      if (scan >= REQ_N) scan = scan - REQ_N;
      sidx = PW'(scan);
      if (!found && req_val_i[sidx]) begin
        found = 1'b1;
        gnt   = sidx;
      end
    end
  end

  // Only the pre-pop count gates a push, so a same-cycle pop never frees a slot.
  logic can_push, push, pop;
  assign can_push    = cnt_q < (AW+1)'(TAG_DEPTH);
  // rst_n_i gating keeps ready low during reset even with requests pending.
  assign req_ready_o = (found && can_push && rst_n_i) ? (REQ_N'(1) << gnt) : '0;
  assign push        = |req_ready_o;
  assign pop         = bpc_data_val_i && (cnt_q != '0);

  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (gnt == PW'(REQ_N-1)) ? '0 : gnt + PW'(1);
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      bpc_data_q <= '0;
      bpc_val_q  <= 1'b0;
      res_data_q <= '0;
      res_val_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      bpc_val_q <= push;
      if (push) begin
        wr_q       <= wr_q + 1'b1;
        bpc_data_q <= words[gnt];
      end
      if (pop) begin
        rd_q       <= rd_q + 1'b1;
        res_data_q <= bpc_data_i;
        res_val_q  <= REQ_N'(1) << tag_mem[rd_q];
      end else begin
        res_val_q  <= '0;
      end
    end
  end

  // Tag storage needs no reset: the count decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_q] <= gnt;
  end

  assign bpc_data_o     = bpc_data_q;
  assign bpc_data_val_o = bpc_val_q;
  assign res_data_o     = res_data_q;
  assign res_val_o      = res_val_q;

`ifdef BPC_ARB_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                err_q <= 1'b0;
    else if (bpc_data_val_i && (cnt_q == '0))    err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bpc_arbiter.sv
module tb_bpc_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_val;
  logic [3:0]  req_ready;
  logic [7:0]  bpc_data;
  logic        bpc_val;
  logic [3:0]  cnt_data;
  logic        cnt_val;
  logic [3:0]  res_data;
  logic [3:0]  res_val;
  logic        err;

  // Counter stand-in: zero-latency popcount of the issued word, or manual
  // drive for stall/orphan sequences.
  logic        auto_en;
  logic        man_val;
  logic [3:0]  man_data;
  assign cnt_val  = auto_en ? bpc_val : man_val;
  assign cnt_data = auto_en ? 4'($countones(bpc_data)) : man_data;

  always #5 clk = ~clk;

  bpc_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_data_i(req_data), .req_val_i(req_val), .req_ready_o(req_ready),
    .bpc_data_o(bpc_data), .bpc_data_val_o(bpc_val),
    .bpc_data_i(cnt_data), .bpc_data_val_i(cnt_val),
    .res_data_o(res_data), .res_val_o(res_val), .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  val;
    logic [31:0] data;
    logic [3:0]  rdy;
    logic        bv;
    logic [7:0]  bd;
    logic [3:0]  rv;
    logic [3:0]  rd;
  } vec_t;
  vec_t tbl [15];

  logic exp_err;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef BPC_ARB_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // ready is checked right after drive, the rest after the next edge.
    // Results trail issue by one row with the zero-latency counter.
    tbl[0]  = '{4'b0010, 32'h0000B700, 4'b0010, 1'b1, 8'hB7, 4'b0000, 4'd0};
    tbl[1]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'hB7, 4'b0010, 4'd6};
    tbl[2]  = '{4'b1000, 32'hFF000000, 4'b1000, 1'b1, 8'hFF, 4'b0000, 4'd6};
    tbl[3]  = '{4'b0001, 32'h00000001, 4'b0001, 1'b1, 8'h01, 4'b1000, 4'd8};
    tbl[4]  = '{4'b1000, 32'hFF000000, 4'b1000, 1'b1, 8'hFF, 4'b0001, 4'd1};
    tbl[5]  = '{4'b1111, 32'h0F070301, 4'b0001, 1'b1, 8'h01, 4'b1000, 4'd8};
    tbl[6]  = '{4'b1111, 32'h0F070301, 4'b0010, 1'b1, 8'h03, 4'b0001, 4'd1};
    tbl[7]  = '{4'b1111, 32'h0F070301, 4'b0100, 1'b1, 8'h07, 4'b0010, 4'd2};
    tbl[8]  = '{4'b1111, 32'h0F070301, 4'b1000, 1'b1, 8'h0F, 4'b0100, 4'd3};
    tbl[9]  = '{4'b1111, 32'h0F070301, 4'b0001, 1'b1, 8'h01, 4'b1000, 4'd4};
    tbl[10] = '{4'b1111, 32'h0F070301, 4'b0010, 1'b1, 8'h03, 4'b0001, 4'd1};
    tbl[11] = '{4'b1111, 32'h0F070301, 4'b0100, 1'b1, 8'h07, 4'b0010, 4'd2};
    tbl[12] = '{4'b1111, 32'h0F070301, 4'b1000, 1'b1, 8'h0F, 4'b0100, 4'd3};
    tbl[13] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h0F, 4'b1000, 4'd4};
    tbl[14] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h0F, 4'b0000, 4'd4};

    auto_en = 1'b1; man_val = 1'b0; man_data = 4'd0;
    rst_n = 1'b0; req_val = 4'b1111; req_data = 32'h0F070301;
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_bpc_val", 32'(bpc_val), 32'h0);
    chk("rst_bpc_data", 32'(bpc_data), 32'h0);
    chk("rst_res_val", 32'(res_val), 32'h0);
    chk("rst_res_data", 32'(res_data), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk); rst_n = 1'b1; req_val = 4'b0000; req_data = '0;

    // Single requester, routing and round-robin fairness.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      req_val = tbl[i].val; req_data = tbl[i].data;
      #1 chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_bpc_val", i), 32'(bpc_val), 32'(tbl[i].bv));
      chk($sformatf("v%0d_bpc_data", i), 32'(bpc_data), 32'(tbl[i].bd));
      chk($sformatf("v%0d_res_val", i), 32'(res_val), 32'(tbl[i].rv));
      chk($sformatf("v%0d_res_data", i), 32'(res_data), 32'(tbl[i].rd));
    end

    // Full FIFO: returns stalled, eight words fill the tag FIFO.
    @(negedge clk); auto_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      req_val = 4'b0001; req_data = 32'h00000001;
      #1 chk($sformatf("fill%0d_ready", i), 32'(req_ready), 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_data = 32'h000000AA;
      #1 chk($sformatf("full%0d_ready", i), 32'(req_ready), 32'h0);
    end
    @(negedge clk); man_val = 1'b1; man_data = 4'd1;
    #1 chk("pop_cycle_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1;
    chk("pop_res_val", 32'(res_val), 32'h1);
    chk("pop_res_data", 32'(res_data), 32'h1);
    chk("after_pop_ready", 32'(req_ready), 32'h1);
    @(negedge clk); man_val = 1'b0;
    @(posedge clk); #1;
    chk("ninth_bpc_val", 32'(bpc_val), 32'h1);
    chk("ninth_bpc_data", 32'(bpc_data), 32'hAA);
    chk("refull_ready", 32'(req_ready), 32'h0);
    @(negedge clk); req_val = 4'b0000; man_val = 1'b1; man_data = 4'd2;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("drain%0d_res_val", i), 32'(res_val), 32'h1);
    end
    @(negedge clk); man_val = 1'b0;

    // Orphan result with empty FIFO.
    @(negedge clk); man_val = 1'b1; man_data = 4'd5;
    @(posedge clk); #1;
    chk("orphan_res_val", 32'(res_val), 32'h0);
    chk("orphan_res_data", 32'(res_data), 32'h2);
    chk("orphan_err", 32'(err), 32'(exp_err));
    @(negedge clk); man_val = 1'b0;
    @(posedge clk); #1;
    chk("orphan_err_held", 32'(err), 32'(exp_err));
    chk("orphan_res_val2", 32'(res_val), 32'h0);

    // Asynchronous reset mid-burst.
    @(negedge clk); auto_en = 1'b1; req_val = 4'b1111; req_data = 32'h0F070301;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(req_ready), 32'h0);
    chk("arst_bpc_val", 32'(bpc_val), 32'h0);
    chk("arst_bpc_data", 32'(bpc_data), 32'h0);
    chk("arst_res_val", 32'(res_val), 32'h0);
    chk("arst_res_data", 32'(res_data), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    @(negedge clk); req_val = 4'b0000;
    @(negedge clk); rst_n = 1'b1; req_val = 4'b1111;
    #1 chk("restart_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("restart_bpc_data", 32'(bpc_data), 32'h01);
    chk("restart_bpc_val", 32'(bpc_val), 32'h1);
    @(negedge clk); req_val = 4'b0000;
    @(posedge clk); #1;
    chk("restart_res_val", 32'(res_val), 32'h1);
    chk("restart_res_data", 32'(res_data), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bpc_arbiter.md
# bpc_arbiter

Round-robin arbiter that shares one `bit_population_counter` instance among `REQ_N` requesters. Accepts words over per-requester valid/ready handshakes and issues at most one word per cycle to the counter. Records the owner of every issued word in a tag FIFO and routes each returned popcount back to its owner with a one-hot valid. Sits between the requester blocks and the counter; the counter's own interface is unchanged.

## Interface
- `REQ_N`, 4, number of requesters (2..16)
- `WIDTH`, 8, data word width; must match the counter's `WIDTH`
- `TAG_DEPTH`, 8, maximum words in flight inside the counter (power of two, ≥2)

Ports:
- `clk_i`  in  1  single clock, rising edge
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `req_data_i`  in  `REQ_N*WIDTH`  requester k's word in bits `[k*WIDTH +: WIDTH]`
- `req_val_i`  in  `REQ_N`  requester k has a word
- `req_ready_o`  out  `REQ_N`  requester k's word is taken this cycle
- `bpc_data_o`  out  `WIDTH`  word to the counter's `data_i`
- `bpc_data_val_o`  out  1  to the counter's `data_val_i`
- `bpc_data_i`  in  `$clog2(WIDTH)+1`  from the counter's `data_o`
- `bpc_data_val_i`  in  1  from the counter's `data_val_o`
- `res_data_o`  out  `$clog2(WIDTH)+1`  popcount result, shared by all requesters
- `res_val_o`  out  `REQ_N`  one-hot; bit k marks the result as belonging to requester k
- `err_o`  out  1  sticky error flag (see Configuration)

## Operation
- **Round-robin pointer `rr_ptr`** (`$clog2(REQ_N)` bits, reset 0).
  - The grant goes to the first k with `req_val_i[k]=1`, searching from `rr_ptr` upward with wrap-around.
- **Grant condition:** any valid request and tag count < `TAG_DEPTH`.
  - A pop in the same cycle does not free a slot for a push.
- **Ready:** `req_ready_o` is combinational and one-hot or zero. Only the granted bit is set, and only when the grant condition holds.
- **Transfer:** occurs when `req_val_i[k] & req_ready_o[k]`. On a transfer:
  - push k into the tag FIFO;
  - set `rr_ptr` to (k+1) mod `REQ_N`;
  - register the word to `bpc_data_o`;
  - drive `bpc_data_val_o=1` for exactly one cycle.
- **No transfer:** `rr_ptr` holds, `bpc_data_val_o=0`, and `bpc_data_o` holds its last value.
- **Return:** when `bpc_data_val_i=1` and the FIFO is non-empty:
  - pop the head tag t;
  - register `res_data_o` from `bpc_data_i`;
  - set `res_val_o = 1<<t` for one cycle.
  - Results return in issue order.
- **Return with empty FIFO:** the result is dropped, `res_val_o` stays 0, and the error condition is raised.
- **Backpressure:** there is none on results. Requesters must accept `res_val_o` in any cycle.
- **Simultaneous push and pop** are both performed, and the count is unchanged.
- **Tag FIFO:** circular buffer with `$clog2(TAG_DEPTH)`-bit read/write pointers that wrap, plus a `$clog2(TAG_DEPTH)+1`-bit count.

## Timing
- **Reset values:** while `rst_n_i=0`, or asynchronously on its falling edge:
  - `req_ready_o=0`, `bpc_data_o=0`, `bpc_data_val_o=0`, `res_data_o=0`, `res_val_o=0`, `err_o=0`;
  - FIFO empty, `rr_ptr=0`.
- **Issue latency:** a transfer in cycle n gives `bpc_data_val_o=1` in cycle n+1.
- **Result latency:** `bpc_data_val_i` in cycle m gives `res_val_o` in cycle m+1. End-to-end latency is the counter latency + 2.
- **Throughput:** one word per cycle while the FIFO is not full. With the FIFO full, all `req_ready_o` are 0 until a pop.
- **Reset mid-operation:** in-flight tags are discarded.
  - Results returned after reset hit an empty FIFO and are dropped.
  - Integrators reset the counter together with this block.

## Configuration
- **`BPC_ARB_ERR_EN` defined:** `err_o` is set on a return with an empty FIFO and stays 1 until reset.
- **`BPC_ARB_ERR_EN` undefined:** `err_o` is tied to 0 and no detection logic is built. Orphan results are still dropped silently.

## Test plan
- **Single requester:** reset, then `req_val_i=4'b0010`, `req_data_i[15:8]=8'hB7` for one cycle.
  - Expect `bpc_data_o=8'hB7` with valid on the next cycle.
  - Expect `res_data_o=6`, `res_val_o=4'b0010` one cycle after the counter returns.
- **Round-robin fairness:** all four requesters held valid for 8 cycles. Grant order must be 0,1,2,3,0,1,2,3, with one `req_ready_o` bit per cycle.
- **Routing:** requester 3 sends `8'hFF`, then requester 0 sends `8'h01` back to back.
  - Expect `res_val_o=4'b1000` with 8, then `4'b0001` with 1, in consecutive result cycles.
- **Full FIFO:** stall counter returns and issue 8 words.
  - The 9th request sees `req_ready_o=0` until the first return.
  - It is then accepted on the cycle after the pop.
- **Orphan result:** pulse `bpc_data_val_i` with the FIFO empty.
  - Expect `res_val_o=0`.
  - Expect `err_o=1` and held when `BPC_ARB_ERR_EN` is defined; `err_o=0` otherwise.
- **Async reset:** assert `rst_n_i` mid-burst between clock edges. All outputs must go to 0 immediately, and traffic must restart from requester 0 after release.
